// File: rtl/mem_access_unit.sv
// Memory-stage access unit: drives a request/acknowledge data-memory port,
// stalls the pipeline while an access is outstanding and resolves branches.
module mem_access_unit #(
    parameter int N       = 64,
    parameter int TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         memRead_M,
    input  logic         memWrite_M,
    input  logic         Branch_M,
    input  logic         zero_M,
    input  logic [N-1:0] aluResult_M,
    input  logic [N-1:0] writeData_M,
    output logic         PCSrc_M,
    output logic [N-1:0] readData_M,
    output logic         stall_M,
    output logic         memErr_M,
    output logic         dm_req,
    output logic         dm_we,
    output logic [N-1:0] dm_addr,
    output logic [N-1:0] dm_wdata,
    input  logic [N-1:0] dm_rdata,
    input  logic         dm_ack
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CntLast = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t         r_state;
    state_t         w_next;
    logic [CW-1:0]  r_cnt;
    logic [N-1:0]   r_addr;
    logic [N-1:0]   r_wdata;
    logic [N-1:0]   r_rdata;
    logic           r_we;
    logic           r_err;
    logic           w_access;
    logic           w_aligned;
    logic           w_is_read;
    logic           w_timeout;
    logic           w_stall;
    logic           w_req;

    // A simultaneous read and write is handled as a write.
    assign w_access  = memRead_M | memWrite_M;
    assign w_aligned = (aluResult_M[2:0] == 3'b000);
    assign w_is_read = memRead_M & ~memWrite_M;
    assign w_timeout = (r_cnt == CntLast);

    assign PCSrc_M    = Branch_M & zero_M;
    assign stall_M    = w_stall & reset;
    assign dm_req     = w_req;
    assign dm_we      = r_we;
    assign dm_addr    = r_addr;
    assign dm_wdata   = r_wdata;
    assign readData_M = r_rdata;
    assign memErr_M   = (r_state == DONE) & r_err;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode plus stall and request outputs.
    always_comb begin
        w_next  = r_state;
        w_stall = 1'b0;
        w_req   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_access) begin
                    w_stall = 1'b1;
                    w_next  = w_aligned ? REQ : DONE;
                end
            end
            REQ: begin
                w_stall = 1'b1;
                w_req   = 1'b1;
                if (dm_ack || w_timeout) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Request capture, wait counter, load data and error flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_we    <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_access) begin
                        if (w_aligned) begin
                            r_addr  <= aluResult_M;
                            r_wdata <= writeData_M;
                            r_we    <= memWrite_M;
                            r_cnt   <= '0;
                            r_err   <= 1'b0;
                        end else begin
                            r_err <= 1'b1;
                            if (w_is_read) begin
                                r_rdata <= '0;
                            end
                        end
                    end
                end
                REQ: begin
                    if (dm_ack) begin
                        r_err <= 1'b0;
                        if (!r_we) begin
                            r_rdata <= dm_rdata;
                        end
                    end else if (w_timeout) begin
                        r_err <= 1'b1;
                        if (!r_we) begin
                            r_rdata <= '0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: stimulus pushes expected outcomes,
// a negedge monitor pops them when the access completes.
module tb_mem_access_unit;

    localparam int N = 64;

    logic         clk;
    logic         reset;
    logic         memRead_M;
    logic         memWrite_M;
    logic         Branch_M;
    logic         zero_M;
    logic [N-1:0] aluResult_M;
    logic [N-1:0] writeData_M;
    logic         PCSrc_M;
    logic [N-1:0] readData_M;
    logic         stall_M;
    logic         memErr_M;
    logic         dm_req;
    logic         dm_we;
    logic [N-1:0] dm_addr;
    logic [N-1:0] dm_wdata;
    logic [N-1:0] dm_rdata;
    logic         dm_ack;

    mem_access_unit #(.N(N), .TIMEOUT(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .memRead_M   (memRead_M),
        .memWrite_M  (memWrite_M),
        .Branch_M    (Branch_M),
        .zero_M      (zero_M),
        .aluResult_M (aluResult_M),
        .writeData_M (writeData_M),
        .PCSrc_M     (PCSrc_M),
        .readData_M  (readData_M),
        .stall_M     (stall_M),
        .memErr_M    (memErr_M),
        .dm_req      (dm_req),
        .dm_we       (dm_we),
        .dm_addr     (dm_addr),
        .dm_wdata    (dm_wdata),
        .dm_rdata    (dm_rdata),
        .dm_ack      (dm_ack)
    );

    typedef struct {
        logic [N-1:0] addr;
        logic [N-1:0] wdata;
        logic [N-1:0] rdata;
        logic         we;
        logic         err;
        int           stall;
        int           req;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    bit   mon_en   = 1'b0;
    int   stall_cnt = 0;
    int   req_cnt   = 0;
    bit   unstable  = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: branch resolution every cycle, transaction outcome on the
    // first non-stalled cycle of a pending access.
    always @(negedge clk) begin
        if (mon_en) begin
            check("pcsrc", N'(PCSrc_M), N'(Branch_M & zero_M));
            if (memRead_M || memWrite_M) begin
                if (stall_M) begin
                    stall_cnt++;
                    if (dm_req) begin
                        req_cnt++;
                        if (q.size() > 0 && (dm_addr !== q[0].addr ||
                            dm_wdata !== q[0].wdata || dm_we !== q[0].we)) begin
                            unstable = 1'b1;
                        end
                    end
                end else if (q.size() == 0) begin
                    check("unexpected_completion", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("readData", readData_M, e.rdata);
                    check("memErr", N'(memErr_M), N'(e.err));
                    check("dm_req_in_done", N'(dm_req), 0);
                    check("stall_cycles", N'(stall_cnt), N'(e.stall));
                    check("req_cycles", N'(req_cnt), N'(e.req));
                    check("req_stable", N'(unstable), 0);
                    stall_cnt = 0;
                    req_cnt   = 0;
                    unstable  = 1'b0;
                end
            end
        end
    end

    // ack_k = REQ cycle that carries dm_ack (0 = never).
    task automatic access(input logic rd, input logic wr, input logic [N-1:0] addr,
                          input logic [N-1:0] wd, input int ack_k, input logic [N-1:0] rdat,
                          input logic br, input exp_t e);
        int  k;
        bit  done;
        q.push_back(e);
        @(posedge clk); #1;
        memRead_M   = rd;
        memWrite_M  = wr;
        aluResult_M = addr;
        writeData_M = wd;
        Branch_M    = br;
        k    = 0;
        done = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            dm_ack   = 1'b0;
            zero_M   = ~zero_M;
            if (!stall_M) begin
                done = 1'b1;
                break;
            end
            k++;
            if (k == ack_k) begin
                dm_ack   = 1'b1;
                dm_rdata = rdat;
            end
        end
        if (!done) begin
            check("access_timeout", 0, 1);
        end
        @(posedge clk); #1;
        memRead_M  = 1'b0;
        memWrite_M = 1'b0;
        dm_ack     = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        memRead_M = 1'b0; memWrite_M = 1'b0; Branch_M = 1'b0; zero_M = 1'b0;
        aluResult_M = '0; writeData_M = '0; dm_rdata = '0; dm_ack = 1'b0;
        #3;
        check("rst_dm_req", N'(dm_req), 0);
        check("rst_dm_we", N'(dm_we), 0);
        check("rst_stall", N'(stall_M), 0);
        check("rst_memErr", N'(memErr_M), 0);
        check("rst_readData", readData_M, 0);
        check("rst_dm_addr", dm_addr, 0);
        check("rst_dm_wdata", dm_wdata, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        Branch_M = 1'b1; zero_M = 1'b1; #1;
        check("branch_taken_idle", N'(PCSrc_M), 1);
        zero_M = 1'b0; #1;
        check("branch_not_taken_idle", N'(PCSrc_M), 0);
        mon_en = 1'b1;

        //     rd  wr  addr    wdata  k   rdata                 br    {addr, wdata, rdata, we, err, stall, req}
        access(1, 0, 64'h40, 64'h0, 2, 64'hDEADBEEF, 1,
               '{64'h40, 64'h0, 64'hDEADBEEF, 1'b0, 1'b0, 3, 2});
        access(0, 1, 64'h08, 64'h1234, 3, 64'hFFFF, 1,
               '{64'h08, 64'h1234, 64'hDEADBEEF, 1'b1, 1'b0, 4, 3});
        access(1, 0, 64'h0C, 64'h0, 1, 64'h77, 1,
               '{64'h0, 64'h0, 64'h0, 1'b0, 1'b1, 1, 0});
        access(1, 0, 64'h100, 64'h0, 1, 64'hCAFEF00D12345678, 0,
               '{64'h100, 64'h0, 64'hCAFEF00D12345678, 1'b0, 1'b0, 2, 1});
        access(1, 1, 64'h10, 64'hAA, 1, 64'h99, 1,
               '{64'h10, 64'hAA, 64'hCAFEF00D12345678, 1'b1, 1'b0, 2, 1});
        access(1, 0, 64'h18, 64'h0, 0, 64'h0, 1,
               '{64'h18, 64'h0, 64'h0, 1'b0, 1'b1, 17, 16});
        access(0, 1, 64'h21, 64'h5A, 1, 64'h0, 0,
               '{64'h0, 64'h0, 64'h0, 1'b0, 1'b1, 1, 0});
        access(1, 0, 64'h28, 64'h0, 16, 64'h55, 1,
               '{64'h28, 64'h0, 64'h55, 1'b0, 1'b0, 17, 16});

        // Stray ack while idle must not disturb load data.
        @(posedge clk); #1;
        dm_ack = 1'b1; dm_rdata = 64'h1111;
        @(posedge clk); #1;
        dm_ack = 1'b0;
        @(negedge clk);
        check("idle_ack_ignored", readData_M, 64'h55);
        check("idle_ack_no_req", N'(dm_req), 0);
        check("queue_drained", N'(q.size()), 0);

        // Reset in the middle of a request, followed by a late ack.
        mon_en = 1'b0;
        @(posedge clk); #1;
        memRead_M = 1'b1; aluResult_M = 64'h30;
        repeat (3) @(posedge clk);
        #1;
        check("midreq_req_high", N'(dm_req), 1);
        reset = 1'b0; #1;
        check("midreq_rst_req", N'(dm_req), 0);
        check("midreq_rst_stall", N'(stall_M), 0);
        check("midreq_rst_readData", readData_M, 0);
        check("midreq_rst_addr", dm_addr, 0);
        memRead_M = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        dm_ack = 1'b1; dm_rdata = 64'hFF;
        @(posedge clk); #1;
        dm_ack = 1'b0;
        @(negedge clk);
        check("late_ack_readData", readData_M, 0);
        check("late_ack_req", N'(dm_req), 0);
        check("late_ack_memErr", N'(memErr_M), 0);
        check("late_ack_stall", N'(stall_M), 0);
        Branch_M = 1'b1; zero_M = 1'b1; #1;
        check("branch_after_reset", N'(PCSrc_M), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
